// File: rtl/multicycle_chunk_adder_pkg.sv
// multicycle_chunk_adder_pkg: shared FSM states and default geometry for the chunked adder
package multicycle_chunk_adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/multicycle_chunk_adder_if.sv
// multicycle_chunk_adder_if: start/busy/done handshake plus operand and result bus
interface multicycle_chunk_adder_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  modport master(output start, A, B, Cin, sub, input busy, done, Sum, Carry, Overflow);
  modport slave(input start, A, B, Cin, sub, output busy, done, Sum, Carry, Overflow);
endinterface

// File: rtl/multicycle_chunk_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder made of full-adder bit cells
module chunk_adder #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic c;
  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder: WIDTH-bit add/sub processed CHUNK bits per clock, LSB chunk first
module multicycle_chunk_adder
  import multicycle_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic clk,
  input logic reset,
  multicycle_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = $clog2(NCHUNK) + 1;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nx, sum_q;
  logic carry_reg, carry_q, ovf_q, cout, last, load;
  logic [CHUNK-1:0] s;
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a(a_reg[CHUNK-1:0]), .b(b_reg[CHUNK-1:0]), .cin(carry_reg), .s(s), .cout(cout)
  );
  // operands shift right each cycle so the active chunk always sits in the low bits;
  // on the last chunk those low bits hold the original MSBs used for overflow
  assign sum_nx = (sum_reg >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
  assign last = idx == IW'(NCHUNK - 1);
  assign load = bus.start && state != ST_RUN;
  always_comb begin
    state_nx = (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) : (bus.start ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx <= '0;
      a_reg <= '0;
      b_reg <= '0;
      sum_reg <= '0;
      carry_reg <= 1'b0;
      sum_q <= '0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        a_reg <= bus.A;
        b_reg <= bus.sub ? ~bus.B : bus.B;
        carry_reg <= bus.sub | bus.Cin;
        idx <= '0;
      end else if (state == ST_RUN) begin
        a_reg <= a_reg >> CHUNK;
        b_reg <= b_reg >> CHUNK;
        sum_reg <= sum_nx;
        carry_reg <= cout;
        idx <= idx + IW'(1);
        if (last) begin
          sum_q <= sum_nx;
          carry_q <= cout;
          ovf_q <= (a_reg[CHUNK-1] == b_reg[CHUNK-1]) && (s[CHUNK-1] != a_reg[CHUNK-1]);
        end
      end
    end
  end
  assign bus.busy = state == ST_RUN;
  assign bus.done = state == ST_DONE;
  assign bus.Sum = sum_q;
  assign bus.Carry = carry_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// tb_multicycle_chunk_adder: directed checks of the single-cycle and 4-chunk configurations
module tb_multicycle_chunk_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int bc;
  int dc;
  always #5 clk = ~clk;
  multicycle_chunk_adder_if #(.WIDTH(8)) b8 ();
  multicycle_chunk_adder_if #(.WIDTH(32)) b32 ();
  multicycle_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8 (.clk(clk), .reset(reset), .bus(b8.slave));
  multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic s);
    b32.A = a;
    b32.B = b;
    b32.Cin = cin;
    b32.sub = s;
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (b32.done) break;
      if (b32.busy) busy_cyc++;
      @(negedge clk);
    end
    chk("done_seen", 64'(b32.done), 64'd1);
  endtask

  initial begin
    b8.start = 0; b8.A = 0; b8.B = 0; b8.Cin = 0; b8.sub = 0;
    b32.start = 0; b32.A = 0; b32.B = 0; b32.Cin = 0; b32.sub = 0;
    repeat (2) @(negedge clk);
    chk("rst_sum32", 64'(b32.Sum), 64'd0);
    chk("rst_flags32", {61'd0, b32.Carry, b32.Overflow, b32.busy}, 64'd0);
    chk("rst_done32", 64'(b32.done), 64'd0);
    chk("rst_sum8", 64'(b8.Sum), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    // single-cycle configuration: 100+100+1
    b8.A = 8'd100; b8.B = 8'd100; b8.Cin = 1'b1; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    chk("w8_busy", {b8.busy, b8.done}, 64'b10);
    @(negedge clk);
    chk("w8_done", {b8.busy, b8.done}, 64'b01);
    chk("w8_sum", 64'(b8.Sum), 64'd201);
    chk("w8_carry_ovf", {b8.Carry, b8.Overflow}, 64'b01);
    @(negedge clk);
    chk("w8_idle", 64'(b8.done), 64'd0);
    chk("w8_hold", 64'(b8.Sum), 64'd201);
    // carry ripples through all chunk boundaries
    go(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done(bc);
    chk("ripple_busy_cycles", 64'(bc), 64'd4);
    chk("ripple_sum", 64'(b32.Sum), 64'd0);
    chk("ripple_carry_ovf", {b32.Carry, b32.Overflow}, 64'b10);
    @(negedge clk);
    chk("ripple_one_done", 64'(b32.done), 64'd0);
    go(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(bc);
    chk("sub_borrow_sum", 64'(b32.Sum), 64'hFFFF_FFFE);
    chk("sub_borrow_flags", {b32.Carry, b32.Overflow}, 64'b00);
    @(negedge clk);
    go(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    wait_done(bc);
    chk("sub_ovf_sum", 64'(b32.Sum), 64'h7FFF_FFFF);
    chk("sub_ovf_flags", {b32.Carry, b32.Overflow}, 64'b11);
    // back-to-back start while DONE
    go(32'd59, 32'd48, 1'b0, 1'b0);
    chk("b2b_no_idle", {b32.busy, b32.done}, 64'b10);
    chk("b2b_hold", 64'(b32.Sum), 64'h7FFF_FFFF);
    wait_done(bc);
    chk("b2b_sum", 64'(b32.Sum), 64'd107);
    chk("b2b_flags", {b32.Carry, b32.Overflow}, 64'b00);
    @(negedge clk);
    // start during RUN must be ignored
    go(32'd10, 32'd20, 1'b0, 1'b0);
    b32.A = 32'd1000; b32.B = 32'd1; b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    wait_done(bc);
    chk("ignore_sum", 64'(b32.Sum), 64'd30);
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b32.done) dc++;
    end
    chk("ignore_single_done", 64'(dc), 64'd0);
    // reset in the second RUN cycle
    go(32'd1, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_sum", 64'(b32.Sum), 64'd0);
    chk("arst_state", {b32.busy, b32.done}, 64'b00);
    dc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b32.done) dc++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b32.done) dc++;
    end
    chk("arst_no_done", 64'(dc), 64'd0);
    go(32'd89, 32'd67, 1'b1, 1'b0);
    wait_done(bc);
    chk("post_rst_sum", 64'(b32.Sum), 64'd157);
    chk("post_rst_busy_cycles", 64'(bc), 64'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_chunk_adder.md
Name: multicycle_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the fixed 8-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, and carries between cycles in a register. A start/busy/done handshake lets wide additions share one small CHUNK-bit ripple stage. Used by datapath blocks that need wide arithmetic without a long combinational carry chain.

Parameters:
WIDTH, 32, operand/result width in bits; must be a positive multiple of CHUNK
CHUNK, 8, bits added per cycle; CHUNK == WIDTH gives single-cycle operation
NCHUNK, WIDTH/CHUNK, derived localparam, not overridable; cycles per operation

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when the FSM is in IDLE or DONE
A  input  WIDTH  operand A (unsigned or two's complement)
B  input  WIDTH  operand B
Cin  input  1  carry-in; ignored when sub=1
sub  input  1  0: Sum = A+B+Cin; 1: Sum = A-B (A + ~B + 1)
busy  output  1  high while in RUN
done  output  1  high for exactly one cycle (DONE state); result valid
Sum  output  WIDTH  registered result; holds until the next completion
Carry  output  1  carry-out of the MSB; for sub, 1 means no borrow
Overflow  output  1  signed overflow of the completed operation

Behaviour:
- Reset (async, active-high): state=IDLE; Sum=0, Carry=0, Overflow=0, busy=0, done=0; internal operand regs, chunk index and carry reg cleared. Reset mid-RUN aborts with no done pulse.
- State IDLE: busy=0, done=0. On an edge with start=1, the block:
  - latches A into a_reg and (sub ? ~B : B) into b_reg;
  - sets carry_reg = sub ? 1 : Cin, idx=0, and stores sub;
  - goes to RUN.
- State RUN: busy=1. Each edge:
  - chunk_adder adds a_reg[idx*CHUNK +: CHUNK] + b_reg[same] + carry_reg;
  - the result is written to the internal sum_reg chunk idx;
  - carry_reg takes the chunk carry-out, and idx increments.
- When idx==NCHUNK-1 is processed, the same edge loads Sum from the full assembled sum_reg, sets Carry to the final carry-out, sets Overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb), and moves to DONE.
- State DONE: done=1, busy=0. An edge with start=1 goes to RUN (back-to-back, same latching as IDLE). Otherwise the FSM returns to IDLE.
- Latency: start sampled at edge k; done high in the cycle after edge k+NCHUNK. Throughput is one operation per NCHUNK+1 cycles.
- start during RUN is ignored (no queueing). A, B, Cin and sub may change freely after the start edge.
- Sum, Carry and Overflow change only on the edge entering DONE or on reset. They hold stable through IDLE and the next RUN.
- NCHUNK=1: RUN lasts one cycle; behaviour is otherwise identical.
- Width rules: all additions are modulo 2^WIDTH. Carry is the (WIDTH+1)th bit, with no sign extension.

Decomposition:
- Shared header adder_defs.vh holds:
  - FSM state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH/CHUNK.
- One sub-module, chunk_adder (parameter CHUNK): a combinational CHUNK-bit ripple adder built from the existing full-adder cell. Ports: a, b, cin, s, cout.
- Top level holds the FSM, idx counter (clog2(NCHUNK)+1 bits), operand and sum registers, and carry register.

Test Plan:
1. WIDTH=8, CHUNK=8: A=100, B=100, Cin=1, sub=0 -> done after 1 RUN cycle; Sum=201, Carry=0, Overflow=1.
2. WIDTH=32, CHUNK=8: A=32'hFFFF_FFFF, B=1, Cin=0 -> busy for 4 cycles, then done 1 cycle; Sum=0, Carry=1, Overflow=0. This confirms the carry ripples across all chunk boundaries.
3. WIDTH=32, CHUNK=8, sub=1: A=5, B=7 -> Sum=32'hFFFF_FFFE, Carry=0 (borrow), Overflow=0. Repeat with A=32'h8000_0000, B=1 -> Sum=32'h7FFF_FFFF, Carry=1, Overflow=1.
4. Back-to-back: start=1 in the DONE cycle with A=59, B=48 -> no IDLE cycle; the next done yields Sum=107. The previous Sum holds until that done.
5. Ignored start: pulse start with different operands during RUN -> the result matches the first operands only, with exactly one done pulse.
6. Reset mid-operation: assert reset in RUN cycle 2 -> outputs zero immediately (asynchronous), no done. After release, start A=89, B=67, Cin=1 completes with Sum=157.
